// File: rtl/alu4_op_scheduler.sv
// alu4_op_scheduler
// Shares one external 4-bit ALU between two requesters. A round-robin grant
// latches the winning operands onto registered ALU inputs, holds them for
// SETTLE_CYCLES edges, captures the ALU result and returns it, tagged with the
// requester ID, over a valid/ready response channel.
// Optional per-requester operation counters: define ALU4_SCHED_STATS_EN.
module alu4_op_scheduler #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic [1:0]       req1_op,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [1:0]       alu_op,
   input  logic [3:0]       alu_y,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [3:0]       rsp_y,
   output logic             rsp_cout,
   output logic             busy
`ifdef ALU4_SCHED_STATS_EN
   ,
   output logic [CNT_W-1:0] op_count0,
   output logic [CNT_W-1:0] op_count1
`endif
);

   // Settle window clamped into the 4-bit counter range 1..15.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                               (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF - 1);

   // CNT_W only sizes the statistics counters; a zero width is meaningless.
   if (CNT_W < 1) begin : g_cnt_w_illegal
      logic cnt_w_illegal_s;
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  settle_cnt_r;
   logic        rr_ptr_r;
   logic        grant_vld_s;
   logic        grant_id_s;
   logic [3:0]  sel_a_s;
   logic [3:0]  sel_b_s;
   logic [1:0]  sel_op_s;

   // Round-robin grant; only offered while idle so at most one ready is high.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
      if (state_r == ST_IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = rr_ptr_r;
         end else if (req0_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b0;
         end else if (req1_valid) begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b1;
         end else begin
            grant_vld_s = 1'b0;
         end
      end else begin
         grant_vld_s = 1'b0;
      end
   end

   assign req0_ready = grant_vld_s & ~grant_id_s;
   assign req1_ready = grant_vld_s &  grant_id_s;

   // Operand mux selecting the granted requester's operation.
   always_comb begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
      if (grant_id_s) begin
         sel_a_s  = req1_a;
         sel_b_s  = req1_b;
         sel_op_s = req1_op;
      end else begin
         sel_a_s  = req0_a;
         sel_b_s  = req0_b;
         sel_op_s = req0_op;
      end
   end

   // Next-state logic: accept -> settle window -> hold response until taken.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) begin
               state_nxt_s = ST_SETTLE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_r == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register; busy is registered alongside it so it tracks the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s != ST_IDLE);
      end
   end

   // Datapath: operand latch on accept, settle countdown, result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a        <= 4'd0;
         alu_b        <= 4'd0;
         alu_op       <= 2'd0;
         rsp_id       <= 1'b0;
         rsp_y        <= 4'd0;
         rsp_cout     <= 1'b0;
         rsp_valid    <= 1'b0;
         rr_ptr_r     <= 1'b0;
         settle_cnt_r <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_vld_s) begin
                  alu_a        <= sel_a_s;
                  alu_b        <= sel_b_s;
                  alu_op       <= sel_op_s;
                  rsp_id       <= grant_id_s;
                  rr_ptr_r     <= ~grant_id_s;
                  settle_cnt_r <= SETTLE_LOAD;
               end else begin
                  settle_cnt_r <= settle_cnt_r;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_r != 4'd0) begin
                  settle_cnt_r <= settle_cnt_r - 4'd1;
               end else begin
                  rsp_y     <= alu_y;
                  rsp_cout  <= alu_cout;
                  rsp_valid <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               rsp_valid    <= 1'b0;
               settle_cnt_r <= 4'd0;
            end
         endcase
      end
   end

`ifdef ALU4_SCHED_STATS_EN
   logic hs0_s;
   logic hs1_s;

   assign hs0_s = req0_valid & req0_ready;
   assign hs1_s = req1_valid & req1_ready;

   // Saturating per-requester counts of accepted operations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count0 <= '0;
         op_count1 <= '0;
      end else begin
         if (hs0_s && (op_count0 != {CNT_W{1'b1}})) begin
            op_count0 <= op_count0 + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            op_count0 <= op_count0;
         end
         if (hs1_s && (op_count1 != {CNT_W{1'b1}})) begin
            op_count1 <= op_count1 + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            op_count1 <= op_count1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu4_op_scheduler.sv
// Bench for alu4_op_scheduler: two instances (settle window 1 and 4) driven by
// directed and random steps, checked against a timestamp-based transaction
// model and a behavioural ALU attached to each instance.
module tb_alu4_op_scheduler;

   logic       clk;
   logic       rst_n      [2];
   logic       req0_valid [2];
   logic       req0_ready [2];
   logic [3:0] req0_a     [2];
   logic [3:0] req0_b     [2];
   logic [1:0] req0_op    [2];
   logic       req1_valid [2];
   logic       req1_ready [2];
   logic [3:0] req1_a     [2];
   logic [3:0] req1_b     [2];
   logic [1:0] req1_op    [2];
   logic [3:0] alu_a      [2];
   logic [3:0] alu_b      [2];
   logic [1:0] alu_op     [2];
   logic [4:0] alu_res    [2];
   logic       rsp_valid  [2];
   logic       rsp_ready  [2];
   logic       rsp_id     [2];
   logic [3:0] rsp_y      [2];
   logic       rsp_cout   [2];
   logic       busy       [2];
`ifdef ALU4_SCHED_STATS_EN
   logic [7:0] oc0_0, oc1_0;
   logic [1:0] oc0_1, oc1_1;
`endif

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Reference model state per instance.
   int         settle   [2];
   bit         m_busy   [2];
   int         m_cap    [2];
   bit         m_id     [2];
   bit         m_rr     [2];
   logic [3:0] m_a      [2];
   logic [3:0] m_b      [2];
   logic [1:0] m_op     [2];
   int         m_cnt0   [2];
   int         m_cnt1   [2];
   int         cnt_max  [2];

   // External ALU behaviour: {cout, y}.
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
      case (op)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
         2'd2:    return {1'b0, a & b};
         default: return {1'b1, a ^ b};
      endcase
   endfunction

   assign alu_res[0] = alu_f(alu_a[0], alu_b[0], alu_op[0]);
   assign alu_res[1] = alu_f(alu_a[1], alu_b[1], alu_op[1]);

   alu4_op_scheduler #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]),
      .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]),
      .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req0_op(req0_op[0]),
      .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]),
      .req1_a(req1_a[0]), .req1_b(req1_b[0]), .req1_op(req1_op[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
      .alu_y(alu_res[0][3:0]), .alu_cout(alu_res[0][4]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
      .rsp_y(rsp_y[0]), .rsp_cout(rsp_cout[0]), .busy(busy[0])
`ifdef ALU4_SCHED_STATS_EN
      , .op_count0(oc0_0), .op_count1(oc1_0)
`endif
   );

   alu4_op_scheduler #(.SETTLE_CYCLES(4), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]),
      .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]),
      .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req0_op(req0_op[1]),
      .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]),
      .req1_a(req1_a[1]), .req1_b(req1_b[1]), .req1_op(req1_op[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
      .alu_y(alu_res[1][3:0]), .alu_cout(alu_res[1][4]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
      .rsp_y(rsp_y[1]), .rsp_cout(rsp_cout[1]), .busy(busy[1])
`ifdef ALU4_SCHED_STATS_EN
      , .op_count0(oc0_1), .op_count1(oc1_1)
`endif
   );

   // Free-running clock and edge counter used as the model's timebase.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input int k, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_counts(input int k);
`ifdef ALU4_SCHED_STATS_EN
      check("op_count0", k, (k == 1) ? {6'd0, oc0_1} : oc0_0, 8'(m_cnt0[k]));
      check("op_count1", k, (k == 1) ? {6'd0, oc1_1} : oc1_0, 8'(m_cnt1[k]));
`endif
   endtask

   task automatic model_reset(input int k);
      m_busy[k] = 1'b0;
      m_cap[k]  = 0;
      m_id[k]   = 1'b0;
      m_rr[k]   = 1'b0;
      m_a[k]    = 4'd0;
      m_b[k]    = 4'd0;
      m_op[k]   = 2'd0;
      m_cnt0[k] = 0;
      m_cnt1[k] = 0;
   endtask

   // Asynchronous reset pulse: outputs must clear before any clock edge.
   task automatic do_reset(input int k);
      @(negedge clk);
      req0_valid[k] = 1'b0;
      req1_valid[k] = 1'b0;
      rsp_ready[k]  = 1'b0;
      rst_n[k]      = 1'b0;
      #1;
      model_reset(k);
      check("rst_alu_a",     k, 8'(alu_a[k]), 8'd0);
      check("rst_alu_b",     k, 8'(alu_b[k]), 8'd0);
      check("rst_alu_op",    k, 8'(alu_op[k]), 8'd0);
      check("rst_rsp_valid", k, 8'(rsp_valid[k]), 8'd0);
      check("rst_rsp_id",    k, 8'(rsp_id[k]), 8'd0);
      check("rst_rsp_y",     k, 8'(rsp_y[k]), 8'd0);
      check("rst_rsp_cout",  k, 8'(rsp_cout[k]), 8'd0);
      check("rst_busy",      k, 8'(busy[k]), 8'd0);
      check_counts(k);
      @(negedge clk);
      rst_n[k] = 1'b1;
   endtask

   // One clock cycle on instance k: check registered outputs, apply inputs,
   // check the combinational grant, then advance the model.
   task automatic cycle(input int k,
                        input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [1:0] op0,
                        input bit v1, input logic [3:0] a1, input logic [3:0] b1,
                        input logic [1:0] op1,
                        input bit rr);
      int         n;
      bit         exp_rv;
      bit         g_vld;
      bit         g_id;
      logic [4:0] res;
      @(negedge clk);
      n      = edge_n;
      exp_rv = m_busy[k] && (n >= m_cap[k]);
      res    = alu_f(m_a[k], m_b[k], m_op[k]);
      check("busy",      k, 8'(busy[k]), 8'(m_busy[k]));
      check("rsp_valid", k, 8'(rsp_valid[k]), 8'(exp_rv));
      check("alu_a",     k, 8'(alu_a[k]), 8'(m_a[k]));
      check("alu_b",     k, 8'(alu_b[k]), 8'(m_b[k]));
      check("alu_op",    k, 8'(alu_op[k]), 8'(m_op[k]));
      check("rsp_id",    k, 8'(rsp_id[k]), 8'(m_id[k]));
      if (exp_rv) begin
         check("rsp_y",    k, 8'(rsp_y[k]), 8'(res[3:0]));
         check("rsp_cout", k, 8'(rsp_cout[k]), 8'(res[4]));
      end
      check_counts(k);
      req0_valid[k] = v0;  req0_a[k] = a0;  req0_b[k] = b0;  req0_op[k] = op0;
      req1_valid[k] = v1;  req1_a[k] = a1;  req1_b[k] = b1;  req1_op[k] = op1;
      rsp_ready[k]  = rr;
      #1;
      g_vld = 1'b0;
      g_id  = 1'b0;
      if (!m_busy[k]) begin
         if (v0 && v1) begin
            g_vld = 1'b1;
            g_id  = m_rr[k];
         end else if (v0 || v1) begin
            g_vld = 1'b1;
            g_id  = v1 && !v0;
         end
      end
      check("req0_ready", k, 8'(req0_ready[k]), 8'(g_vld && !g_id));
      check("req1_ready", k, 8'(req1_ready[k]), 8'(g_vld && g_id));
      if (g_vld) begin
         m_busy[k] = 1'b1;
         m_cap[k]  = n + 1 + settle[k];
         m_id[k]   = g_id;
         m_rr[k]   = !g_id;
         m_a[k]    = g_id ? a1 : a0;
         m_b[k]    = g_id ? b1 : b0;
         m_op[k]   = g_id ? op1 : op0;
         if (g_id) m_cnt1[k] = (m_cnt1[k] < cnt_max[k]) ? m_cnt1[k] + 1 : m_cnt1[k];
         else      m_cnt0[k] = (m_cnt0[k] < cnt_max[k]) ? m_cnt0[k] + 1 : m_cnt0[k];
      end else if (exp_rv && rr) begin
         m_busy[k] = 1'b0;
      end
   endtask

   task automatic idle_cycle(input int k, input bit rr);
      cycle(k, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, rr);
   endtask

   task automatic rand_cycle(input int k);
      cycle(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
   endtask

   initial begin
      settle[0] = 1;    settle[1] = 4;
      cnt_max[0] = 255; cnt_max[1] = 3;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0;
         req0_valid[k] = 1'b0; req0_a[k] = 4'd0; req0_b[k] = 4'd0; req0_op[k] = 2'd0;
         req1_valid[k] = 1'b0; req1_a[k] = 4'd0; req1_b[k] = 4'd0; req1_op[k] = 2'd0;
         rsp_ready[k]  = 1'b0;
         model_reset(k);
      end
      repeat (2) @(negedge clk);
      do_reset(0);
      do_reset(1);

      // Single requester right after reset, settle window of one edge.
      cycle(0, 1'b1, 4'hF, 4'h3, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
      repeat (4) idle_cycle(0, 1'b1);

      // Both requesters valid continuously: grants alternate.
      repeat (12) cycle(0, 1'b1, 4'hA, 4'h6, 2'd1, 1'b1, 4'h5, 4'h2, 2'd2, 1'b1);
      repeat (3) idle_cycle(0, 1'b1);

      // Response backpressure with requester 1 waiting.
      repeat (12) cycle(0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 4'h9, 4'hC, 2'd3, 1'b0);
      repeat (4) cycle(0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 4'h9, 4'hC, 2'd3, 1'b1);
      repeat (3) idle_cycle(0, 1'b1);

      repeat (300) rand_cycle(0);

      // Settle window of four edges, then reset during the window.
      cycle(1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 4'h9, 4'h4, 2'd1, 1'b1);
      repeat (8) idle_cycle(1, 1'b1);
      cycle(1, 1'b1, 4'h7, 4'h8, 2'd0, 1'b1, 4'h3, 4'h1, 2'd1, 1'b1);
      repeat (2) idle_cycle(1, 1'b1);
      do_reset(1);
      repeat (3) idle_cycle(1, 1'b1);
      repeat (10) cycle(1, 1'b1, 4'h2, 4'hE, 2'd3, 1'b1, 4'hB, 4'h5, 2'd0, 1'b1);

      // Five requester-0 operations saturate a 2-bit counter.
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 1'b1, 4'(i), 4'hF, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
         repeat (7) idle_cycle(1, 1'b1);
      end

      repeat (300) rand_cycle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
